bp_fe_pred_update_sched: RTL

Training-update scheduler for the frontend predictor tables (BTB/BHT). It owns the single table write port and sequences it. First, after reset, it sweeps every table index with clear writes. It then arbitrates between backend redirect updates, which arrive as pulses and must never stall, and attaboy updates, which arrive through a valid/yumi handshake. It sits between the frontend-queue command decode and the BTB/BHT write interfaces inside the frontend PC generation logic.

---
 rtl/bp_fe_pred_update_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bp_fe_pred_update_sched.sv
// Training-update scheduler for the BTB/BHT write port: post-reset clear sweep,
// then arbitration between never-stalling redirect updates and queued attaboys.
module bp_fe_pred_update_sched #(
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned md_width_p    = 36,
  parameter int unsigned idx_width_p   = 6,
  parameter int unsigned fifo_els_p    = 2,
  parameter int unsigned starve_lim_p  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic                     init_done_o,

  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  input  logic [md_width_p-1:0]    redirect_md_i,
  input  logic                     redirect_taken_i,
  input  logic                     redirect_nonbr_i,

  input  logic                     attaboy_v_i,
  input  logic [vaddr_width_p-1:0] attaboy_pc_i,
  input  logic [md_width_p-1:0]    attaboy_md_i,
  input  logic                     attaboy_taken_i,
  output logic                     attaboy_yumi_o,

  output logic                     upd_v_o,
  output logic                     upd_clr_o,
  output logic [idx_width_p-1:0]   upd_idx_o,
  output logic [vaddr_width_p-1:0] upd_pc_o,
  output logic [md_width_p-1:0]    upd_md_o,
  output logic                     upd_taken_o,
  output logic                     upd_nonbr_o,
  output logic                     upd_redir_o,
  input  logic                     upd_yumi_i,

  output logic [7:0]               drop_cnt_o
);

  localparam int unsigned ptr_width_lp    = $clog2(fifo_els_p);
  localparam int unsigned ptr_full_w_lp   = ptr_width_lp + 1;
  localparam int unsigned starve_width_lp = $clog2(starve_lim_p + 1);
  localparam int unsigned drop_width_lp   = 8;

  typedef struct packed {
    logic [vaddr_width_p-1:0] pc;
    logic [md_width_p-1:0]    md;
    logic                     taken;
    logic                     nonbr;
  } redir_entry_t;

  typedef struct packed {
    logic [vaddr_width_p-1:0] pc;
    logic [md_width_p-1:0]    md;
    logic                     taken;
  } attaboy_entry_t;

  typedef enum logic {e_clear, e_run} state_e;

  state_e                     state_r, state_n;
  logic [idx_width_p-1:0]     sweep_r;
  logic                       hold_v_r;
  redir_entry_t               hold_r;
  logic [drop_width_lp-1:0]   drop_r;
  logic [ptr_full_w_lp-1:0]   wptr_r, rptr_r;
  attaboy_entry_t             fifo_mem_r [fifo_els_p];
  attaboy_entry_t             fifo_head;
  logic [starve_width_lp-1:0] starve_r;

  logic run, fifo_empty, fifo_full, starved;
  logic sel_fifo, sel_hold, fifo_deq, fifo_enq, hold_take;

  assign run        = (state_r == e_run);
  assign fifo_empty = (wptr_r == rptr_r);
  assign fifo_full  = (wptr_r[ptr_width_lp] != rptr_r[ptr_width_lp])
                    && (wptr_r[ptr_width_lp-1:0] == rptr_r[ptr_width_lp-1:0]);
  assign fifo_head  = fifo_mem_r[rptr_r[ptr_width_lp-1:0]];
  assign starved    = (starve_r == starve_width_lp'(starve_lim_p));

  // Starved attaboy head beats the redirect; otherwise redirect has priority.
  assign sel_fifo  = run && !fifo_empty && (starved || !hold_v_r);
  assign sel_hold  = run && hold_v_r && !sel_fifo;
  assign fifo_deq  = sel_fifo && upd_yumi_i;
  assign hold_take = sel_hold && upd_yumi_i;
  assign fifo_enq  = run && attaboy_v_i && !fifo_full;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_clear;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_clear: if (upd_yumi_i && (sweep_r == '1)) state_n = e_run;
      e_run:   state_n = e_run;
      default: state_n = e_clear;
    endcase
  end

  always_comb begin
    upd_v_o        = 1'b0;
    upd_clr_o      = 1'b0;
    upd_idx_o      = '0;
    upd_pc_o       = '0;
    upd_md_o       = '0;
    upd_taken_o    = 1'b0;
    upd_nonbr_o    = 1'b0;
    upd_redir_o    = 1'b0;
    init_done_o    = 1'b0;
    attaboy_yumi_o = 1'b0;
    case (state_r)
      // Reset gates the clear write so nothing is presented while held in reset.
      e_clear: begin
        upd_v_o   = ~reset_i;
        upd_clr_o = ~reset_i;
        upd_idx_o = sweep_r;
      end
      e_run: begin
        init_done_o    = 1'b1;
        attaboy_yumi_o = fifo_enq;
        if (sel_fifo) begin
          upd_v_o     = 1'b1;
          upd_pc_o    = fifo_head.pc;
          upd_md_o    = fifo_head.md;
          upd_taken_o = fifo_head.taken;
        end else if (sel_hold) begin
          upd_v_o     = 1'b1;
          upd_pc_o    = hold_r.pc;
          upd_md_o    = hold_r.md;
          upd_taken_o = hold_r.taken;
          upd_nonbr_o = hold_r.nonbr;
          upd_redir_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                            sweep_r <= '0;
    else if (state_r == e_clear && upd_yumi_i) sweep_r <= sweep_r + idx_width_p'(1);
  end

  // Single-entry redirect hold: a new pulse always wins, losing an unconsumed entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_v_r <= 1'b0;
      hold_r   <= '0;
      drop_r   <= '0;
    end else if (run && redirect_v_i) begin
      hold_v_r <= 1'b1;
      hold_r   <= '{pc: redirect_pc_i, md: redirect_md_i,
                    taken: redirect_taken_i, nonbr: redirect_nonbr_i};
      if (hold_v_r && !hold_take && (drop_r != '1))
        drop_r <= drop_r + drop_width_lp'(1);
    end else if (hold_take) begin
      hold_v_r <= 1'b0;
    end
  end

  assign drop_cnt_o = drop_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (fifo_enq) wptr_r <= wptr_r + ptr_full_w_lp'(1);
      if (fifo_deq) rptr_r <= rptr_r + ptr_full_w_lp'(1);
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (fifo_enq)
      fifo_mem_r[wptr_r[ptr_width_lp-1:0]] <= '{pc: attaboy_pc_i, md: attaboy_md_i,
                                                taken: attaboy_taken_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                    starve_r <= '0;
    else if (fifo_empty || fifo_deq) starve_r <= '0;
    else if (!starved)              starve_r <= starve_r + starve_width_lp'(1);
  end

endmodule
